tayloe_sampler: RTL
===================

// Module: tayloe_sampler
//
// PURPOSE
// - Digital Tayloe-style quadrature detector, directly downstream of the quadrature divider.
// - Consumes the divider's lo_i/lo_q phase strobes and steers each signed input sample
//   into one of four phase integrators (0/90/180/270 deg).
// - After 2**DECIM_LOG2 LO periods it emits I = acc0-acc2 and Q = acc1-acc3
//   with a one-cycle valid strobe.
// - Feeds the downstream baseband filtering stage.
//
// PARAMETERS
// WIDTH       8  signed sample width of sample_in
// DECIM_LOG2  4  log2 of LO periods per output; ACC_W = WIDTH+DECIM_LOG2, OUT_W = ACC_W+1
//
// PORTS
// clk        in   1      system clock; the LO strobes change only on its edges
// n_rst      in   1      asynchronous active-low reset
// lo_i       in   1      LO phase-0 strobe from divider (high 1 of every 4 clk)
// lo_q       in   1      LO phase-1 strobe from divider (high the cycle after lo_i)
// sample_in  in   WIDTH  signed RF sample, one per clk
// i_out      out  OUT_W  signed in-phase result, held between strobes
// q_out      out  OUT_W  signed quadrature result, held between strobes
// out_valid  out  1      1-cycle pulse: i_out/q_out updated
// locked     out  1      phase tracker locked; integration is active
//
// BEHAVIOUR
// Reset (async, n_rst=0):
// - i_out, q_out, out_valid, locked = 0; all accumulators = 0; decim count = 0.
// - Tracker state = UNLOCKED; prev_phase = 3.
//
// Phase decode (combinational from lo_i, lo_q, prev_phase):
// - lo_i & lo_q              -> ILLEGAL.
// - lo_i                     -> phase 0.
// - lo_q                     -> phase 1.
// - neither, prev_phase = 1  -> phase 2.
// - neither, prev_phase = 2  -> phase 3.
// - neither, prev_phase = 0/3 -> ILLEGAL.
// - Legal transitions are only 0->1, 1->2, 2->3, 3->0. Any other sequence is ILLEGAL.
// - prev_phase <= decoded phase each clk; on ILLEGAL, prev_phase <= 3.
//
// Tracker FSM (registered; state changes take effect on the next edge):
// - UNLOCKED: phase 0 -> ALIGN; anything else -> stay.
// - ALIGN: legal step stays ALIGN; phase 0 after 3 -> LOCKED; ILLEGAL -> UNLOCKED.
// - LOCKED: legal step stays; ILLEGAL -> UNLOCKED.
// - locked = (state == LOCKED).
//
// Integration:
// - Active in the cycle whose decode is phase 0 with state ALIGN, i.e. the locking cycle;
//   that sample counts.
// - Active in every legal cycle while LOCKED.
// - Each active cycle: acc[phase] <= acc[phase] + sext(sample_in), ACC_W-bit two's complement.
//   Sized so there is no overflow for any input over one decimation window.
// - A decimation counter (DECIM_LOG2 bits) increments at each active phase-3 cycle.
//
// Output:
// - At the active phase-3 cycle where the counter equals 2**DECIM_LOG2-1:
//   - i_out <= acc0 - acc2.
//   - q_out <= acc1 - (acc3 + sample_in).
//   - Both results are sign-extended to OUT_W.
//   - out_valid <= 1 for exactly one cycle.
//   - All accumulators <= 0 and the counter wraps to 0.
// - Latency: 1 clk from the last contributing sample to out_valid.
// - Outputs hold their value until the next strobe.
//
// Loss of lock (ILLEGAL while ALIGN/LOCKED):
// - That sample is discarded.
// - Accumulators and counter <= 0.
// - No out_valid; i_out/q_out keep their last values.
//
// Simultaneous events:
// - ILLEGAL takes priority over output generation.
// - Reset takes priority over everything.
//
// TESTING
// - Run all scenarios with WIDTH=8, DECIM_LOG2=2 (OUT_W=11, 16 samples per output).
//   Stimulus = divider pattern lo_i,lo_q,0,0 repeating, after reset release.
// 1. sample_in=+5 constant -> locked rises 1 clk after the 2nd lo_i cycle;
//    out_valid 16 samples later; i_out=0, q_out=0.
// 2. sample_in = +10,0,-10,0 phase-aligned to lo_i -> every strobe gives i_out=+80, q_out=0;
//    strobes spaced exactly 16 clk.
// 3. sample_in = 0,+10,0,-10 -> i_out=0, q_out=+80; sample = -128/0/+127/0 -> i_out=-1020 exact.
// 4. Force lo_i=lo_q=1 for one cycle mid-window -> locked=0 next clk, no strobe for that window.
//    Relocks at the 2nd following lo_i; the next result counts only post-relock samples
//    (pattern 2 -> +80).
// 5. Drop one lo_i (4 lows in a row) -> ILLEGAL at the 3rd low; same recovery as scenario 4.
// 6. Assert n_rst mid-window -> all outputs 0 immediately, without a clk edge.
//    After release, behaviour is identical to scenario 1.

Source files
------------

// File: rtl/tayloe_sampler.sv
// Tayloe-style quadrature detector: steers samples into four LO-phase integrators, dumps I/Q per window.
// Latency: out_valid one clk after the last contributing (phase-3) sample of a 2**DECIM_LOG2-period window.
// Backpressure: none; one sample per clk is always consumed and results are held until the next strobe.
module tayloe_sampler #(
    parameter int WIDTH      = 8,
    parameter int DECIM_LOG2 = 4
) (
    input  logic                                clk,
    input  logic                                n_rst,
    input  logic                                lo_i,
    input  logic                                lo_q,
    input  logic signed [WIDTH-1:0]             sample_in,
    output logic signed [WIDTH+DECIM_LOG2:0]    i_out,
    output logic signed [WIDTH+DECIM_LOG2:0]    q_out,
    output logic                                out_valid,
    output logic                                locked
);

    localparam int ACC_W = WIDTH + DECIM_LOG2;
    localparam int OUT_W = ACC_W + 1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ALIGN    = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [1:0]               prev_phase;
    logic [1:0]               phase;
    logic                     illegal;
    logic                     active;
    logic                     dump;
    logic [DECIM_LOG2-1:0]    decim_cnt;
    logic signed [ACC_W-1:0]  acc [4];

    logic signed [ACC_W-1:0]  sample_acc;
    logic signed [OUT_W-1:0]  sample_out;
    logic signed [OUT_W-1:0]  i_res;
    logic signed [OUT_W-1:0]  q_res;

    // Decode the current LO phase from the strobes and the previous phase; only 0->1->2->3->0 is legal.
    always_comb begin
        illegal = 1'b0;
        phase   = 2'd3;
        if (lo_i && lo_q) begin
            illegal = 1'b1;
        end else if (lo_i) begin
            phase   = 2'd0;
            illegal = (prev_phase != 2'd3);
        end else if (lo_q) begin
            phase   = 2'd1;
            illegal = (prev_phase != 2'd0);
        end else if (prev_phase == 2'd1) begin
            phase   = 2'd2;
        end else if (prev_phase == 2'd2) begin
            phase   = 2'd3;
        end else begin
            illegal = 1'b1;
        end
    end

    // Remember the decoded phase; an illegal cycle parks at 3 so the next lo_i is accepted as phase 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_phase <= 2'd3;
        end else if (illegal) begin
            prev_phase <= 2'd3;
        end else begin
            prev_phase <= phase;
        end
    end

    // Tracker next state: first lo_i aligns, second consecutive legal lo_i locks, any illegal step drops lock.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_UNLOCKED: begin
                if (!illegal && phase == 2'd0) begin
                    state_nxt = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (illegal) begin
                    state_nxt = ST_UNLOCKED;
                end else if (phase == 2'd0) begin
                    state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (illegal) begin
                    state_nxt = ST_UNLOCKED;
                end
            end
            default: begin
                state_nxt = ST_UNLOCKED;
            end
        endcase
    end

    // Tracker state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    assign locked = (state == ST_LOCKED);

    // Integration starts on the locking phase-0 sample and continues on every legal locked cycle.
    always_comb begin
        active = 1'b0;
        if (!illegal) begin
            if (state == ST_LOCKED) begin
                active = 1'b1;
            end else if (state == ST_ALIGN && phase == 2'd0) begin
                active = 1'b1;
            end
        end
        dump = active && (phase == 2'd3) && (decim_cnt == {DECIM_LOG2{1'b1}});
    end

    // Result arithmetic; the phase-3 sample of the dump cycle is folded into Q directly.
    always_comb begin
        sample_acc = {{DECIM_LOG2{sample_in[WIDTH-1]}}, sample_in};
        sample_out = {{(DECIM_LOG2 + 1){sample_in[WIDTH-1]}}, sample_in};
        i_res      = {acc[0][ACC_W-1], acc[0]} - {acc[2][ACC_W-1], acc[2]};
        q_res      = {acc[1][ACC_W-1], acc[1]} - ({acc[3][ACC_W-1], acc[3]} + sample_out);
    end

    // Integrators, decimation counter and output registers; loss of lock outranks the window dump.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int k = 0; k < 4; k++) begin
                acc[k] <= '0;
            end
            decim_cnt <= '0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (illegal) begin
                for (int k = 0; k < 4; k++) begin
                    acc[k] <= '0;
                end
                decim_cnt <= '0;
            end else if (dump) begin
                i_out     <= i_res;
                q_out     <= q_res;
                out_valid <= 1'b1;
                for (int k = 0; k < 4; k++) begin
                    acc[k] <= '0;
                end
                decim_cnt <= '0;
            end else if (active) begin
                acc[phase] <= acc[phase] + sample_acc;
                if (phase == 2'd3) begin
                    decim_cnt <= decim_cnt + 1'b1;
                end
            end
        end
    end

endmodule
